// File: rtl/bit_stream_packer_if.sv
// Bundle of serial input, word output and status signals for bit_stream_packer.
// Latency: none; this file holds wiring only, no logic.
// Backpressure: out_ready throttles the output side; the serial input cannot be stalled.
// The word_count signal is present only when PACKER_WORD_COUNT_EN is defined.
interface bit_stream_packer_if #(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 2
);
  localparam int WIDTH = 1 << IDX_W;

  logic              in_valid;
  logic              in_bit;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_parity;
  logic [ADDR_W:0]   fill_level;
  logic [IDX_W-1:0]  bit_index;
  logic              overflow;
`ifdef PACKER_WORD_COUNT_EN
  logic [15:0]       word_count;
`endif

  // Packer side: consumes serial bits and out_ready, produces words and status.
  modport slave (
    input  in_valid, in_bit, out_ready,
    output out_valid, out_data, out_parity, fill_level, bit_index, overflow
`ifdef PACKER_WORD_COUNT_EN
    , output word_count
`endif
  );

  // Environment side: drives serial bits and out_ready, observes words and status.
  modport master (
    output in_valid, in_bit, out_ready,
    input  out_valid, out_data, out_parity, fill_level, bit_index, overflow
`ifdef PACKER_WORD_COUNT_EN
    , input word_count
`endif
  );
endinterface

// File: rtl/bit_stream_packer.sv
// Packs a serial bit stream LSB-first into WIDTH-bit words and queues them in a DEPTH-word FIFO.
// Latency: a word completed at edge N appears on out_valid/out_data right after edge N.
// Backpressure: none upstream; a word that finds the FIFO full (and no pop that cycle) is dropped
// and sets the sticky overflow flag. Optional PACKER_WORD_COUNT_EN adds a count of accepted words.
module bit_stream_packer #(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  bit_stream_packer_if.slave   bus
);
  localparam int WIDTH = 1 << IDX_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  asm_q, asm_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              complete;
  logic              pop;
  logic              push;

  // Assembly, push/pop decisions and FIFO bookkeeping.
  always_comb begin
    asm_d     = asm_q;
    bit_idx_d = bit_idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    ovf_d     = ovf_q;

    if (bus.in_valid) begin
      // Bits are overwritten in place; no clear between words is needed because
      // every position is rewritten before the next completion.
      asm_d[bit_idx_q] = bus.in_bit;
      bit_idx_d        = bit_idx_q + IDX_W'(1);
    end

    complete = bus.in_valid && (bit_idx_q == LAST_IDX);
    pop      = (fill_q != '0) && bus.out_ready;
    // A full FIFO can still take the word if the head leaves in the same cycle.
    push     = complete && ((fill_q != FULL_LVL) || pop);

    if (complete && !push) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    if (push && !pop)      fill_d = fill_q + (ADDR_W + 1)'(1);
    else if (pop && !push) fill_d = fill_q - (ADDR_W + 1)'(1);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      asm_q     <= '0;
      bit_idx_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      bit_idx_q <= bit_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents are qualified by fill level so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= asm_d;
  end

`ifdef PACKER_WORD_COUNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  // Accepted-word counter, wraps at 16 bits; dropped words are not counted.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (push) word_cnt_d = word_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) word_cnt_q <= '0;
    else       word_cnt_q <= word_cnt_d;
  end

  assign bus.word_count = word_cnt_q;
`endif

  // Output view of the FIFO head; data is forced to zero while empty.
  always_comb begin
    bus.out_valid  = (fill_q != '0);
    bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    bus.out_parity = ^bus.out_data;
    bus.fill_level = fill_q;
    bus.bit_index  = bit_idx_q;
    bus.overflow   = ovf_q;
  end
endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer: reset, packing, overflow, full push+pop, gaps, mid-word reset.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: out_ready is driven per scenario to fill, hold and drain the FIFO.
module tb_bit_stream_packer;
  logic clock;
  logic reset;
  int   checks;
  int   passed;

  bit_stream_packer_if #(.IDX_W(2), .ADDR_W(2)) bus ();

  bit_stream_packer #(.IDX_W(2), .ADDR_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed_bit(input logic b);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic feed_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) feed_bit(w[i]);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid act=%b exp=0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 4'h0) $display("FAIL rst_out_data act=%h exp=0", bus.out_data); else passed++;
    checks++; if (bus.out_parity !== 1'b0) $display("FAIL rst_parity act=%b exp=0", bus.out_parity); else passed++;
    checks++; if (bus.fill_level !== 3'd0) $display("FAIL rst_fill act=%0d exp=0", bus.fill_level); else passed++;
    checks++; if (bus.bit_index !== 2'd0) $display("FAIL rst_bit_index act=%0d exp=0", bus.bit_index); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL rst_overflow act=%b exp=0", bus.overflow); else passed++;
  endtask

  task automatic test_single_word();
    do_reset();
    bus.out_ready = 1'b1;
    feed_bit(1'b1); feed_bit(1'b0); feed_bit(1'b1);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL sw_no_bypass act=%b exp=0", bus.out_valid); else passed++;
    feed_bit(1'b1);
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL sw_out_valid act=%b exp=1", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 4'b1101) $display("FAIL sw_out_data act=%b exp=1101", bus.out_data); else passed++;
    checks++; if (bus.out_parity !== 1'b1) $display("FAIL sw_parity act=%b exp=1", bus.out_parity); else passed++;
    tick();
    checks++; if (bus.fill_level !== 3'd0) $display("FAIL sw_fill_after_pop act=%0d exp=0", bus.fill_level); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL sw_valid_after_pop act=%b exp=0", bus.out_valid); else passed++;
  endtask

  task automatic test_overflow();
    logic [3:0] exp_w [4];
    exp_w = '{4'h1, 4'h2, 4'h3, 4'h4};
    do_reset();
    feed_word(4'h1); feed_word(4'h2); feed_word(4'h3); feed_word(4'h4);
    checks++; if (bus.fill_level !== 3'd4) $display("FAIL ov_fill_full act=%0d exp=4", bus.fill_level); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL ov_flag_before act=%b exp=0", bus.overflow); else passed++;
    feed_word(4'hF);
    checks++; if (bus.overflow !== 1'b1) $display("FAIL ov_flag_after act=%b exp=1", bus.overflow); else passed++;
    checks++; if (bus.fill_level !== 3'd4) $display("FAIL ov_fill_after_drop act=%0d exp=4", bus.fill_level); else passed++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[i])
        $display("FAIL ov_drain[%0d] act=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, exp_w[i]);
      else passed++;
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL ov_empty_valid act=%b exp=0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 4'h0) $display("FAIL ov_empty_data act=%h exp=0", bus.out_data); else passed++;
    tick();
    checks++; if (bus.fill_level !== 3'd0) $display("FAIL ov_pop_empty_ignored act=%0d exp=0", bus.fill_level); else passed++;
    checks++; if (bus.overflow !== 1'b1) $display("FAIL ov_sticky act=%b exp=1", bus.overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_w [4];
    exp_w = '{4'h6, 4'h7, 4'h8, 4'h9};
    do_reset();
    feed_word(4'h5); feed_word(4'h6); feed_word(4'h7); feed_word(4'h8);
    feed_bit(1'b1); feed_bit(1'b0); feed_bit(1'b0);
    checks++; if (bus.out_data !== 4'h5) $display("FAIL pp_head_before act=%h exp=5", bus.out_data); else passed++;
    bus.out_ready = 1'b1;
    feed_bit(1'b1);
    checks++; if (bus.fill_level !== 3'd4) $display("FAIL pp_fill act=%0d exp=4", bus.fill_level); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL pp_overflow act=%b exp=0", bus.overflow); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[i])
        $display("FAIL pp_drain[%0d] act=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, exp_w[i]);
      else passed++;
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL pp_empty act=%b exp=0", bus.out_valid); else passed++;
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b0110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.bit_index !== 2'(i)) $display("FAIL gap_idx_before[%0d] act=%0d exp=%0d", i, bus.bit_index, i);
      else passed++;
      feed_bit(bits[i]);
      if (i < 3) begin
        tick(); tick();
        checks++;
        if (bus.bit_index !== 2'(i + 1)) $display("FAIL gap_idx_hold[%0d] act=%0d exp=%0d", i, bus.bit_index, i + 1);
        else passed++;
      end
    end
    checks++; if (bus.bit_index !== 2'd0) $display("FAIL gap_idx_wrap act=%0d exp=0", bus.bit_index); else passed++;
    checks++; if (bus.out_data !== 4'b0110) $display("FAIL gap_data act=%b exp=0110", bus.out_data); else passed++;
    checks++; if (bus.out_parity !== 1'b0) $display("FAIL gap_parity act=%b exp=0", bus.out_parity); else passed++;
    checks++; if (bus.fill_level !== 3'd1) $display("FAIL gap_fill act=%0d exp=1", bus.fill_level); else passed++;
  endtask

  task automatic test_reset_midword();
    do_reset();
    feed_bit(1'b0); feed_bit(1'b1);
    checks++; if (bus.bit_index !== 2'd2) $display("FAIL mr_idx_partial act=%0d exp=2", bus.bit_index); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.bit_index !== 2'd0) $display("FAIL mr_idx_after_reset act=%0d exp=0", bus.bit_index); else passed++;
    feed_word(4'hF);
    checks++; if (bus.out_data !== 4'hF) $display("FAIL mr_data act=%h exp=f", bus.out_data); else passed++;
    checks++; if (bus.fill_level !== 3'd1) $display("FAIL mr_fill act=%0d exp=1", bus.fill_level); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL mr_overflow act=%b exp=0", bus.overflow); else passed++;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mr_single_word act=%b exp=0", bus.out_valid); else passed++;
  endtask

`ifdef PACKER_WORD_COUNT_EN
  task automatic test_word_count();
    do_reset();
    checks++; if (bus.word_count !== 16'd0) $display("FAIL wc_reset act=%0d exp=0", bus.word_count); else passed++;
    for (int i = 0; i < 5; i++) feed_word(4'(i + 1));
    checks++; if (bus.word_count !== 16'd4) $display("FAIL wc_count act=%0d exp=4", bus.word_count); else passed++;
    checks++; if (bus.overflow !== 1'b1) $display("FAIL wc_overflow act=%b exp=1", bus.overflow); else passed++;
    do_reset();
    checks++; if (bus.word_count !== 16'd0) $display("FAIL wc_after_reset act=%0d exp=0", bus.word_count); else passed++;
  endtask
`endif

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_overflow();
    test_full_push_pop();
    test_gaps();
    test_reset_midword();
`ifdef PACKER_WORD_COUNT_EN
    test_word_count();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
